// File: rtl/sparse_weight_accumulator_if.sv
// Bundle of the start/queue/weight-memory/result signals of the sparse weight accumulator.
// The master side is the environment (index queue, weight memory, activation stage); the
// slave side is the accumulator itself.
interface sparse_weight_accumulator_if #(
    parameter int unsigned NODES    = 16,
    parameter int unsigned WEIGHT_W = 8,
    parameter int unsigned ACC_W    = 18
);
    logic                        start;
    logic                        queueEmpty;
    logic [9:0]                  indexIn;
    logic                        dequeue;
    logic [9:0]                  weightAddr;
    logic                        weightRead;
    logic [NODES*WEIGHT_W-1:0]   weightData;
    logic [NODES*ACC_W-1:0]      sums;
    logic                        done;
    logic                        busy;
    logic [9:0]                  activeCount;
    logic                        indexError;

    modport master (
        output start, queueEmpty, indexIn, weightData,
        input  dequeue, weightAddr, weightRead, sums, done, busy, activeCount, indexError
    );

    modport slave (
        input  start, queueEmpty, indexIn, weightData,
        output dequeue, weightAddr, weightRead, sums, done, busy, activeCount, indexError
    );
endinterface

// File: rtl/sparse_weight_accumulator.sv
// Sparse weight accumulator: pops active-pixel indices from the index queue, fetches the
// matching weight row and adds it into NODES parallel saturating signed accumulators.
// Each index costs four cycles (CHECK, POP, FETCH, ACCUM); a pass ends with a done pulse.
module sparse_weight_accumulator #(
    parameter int unsigned NODES       = 16,
    parameter int unsigned WEIGHT_W    = 8,
    parameter int unsigned ACC_W       = 18,
    parameter int unsigned INPUT_NODES = 784
) (
    input logic                        clk,
    input logic                        resetAccumulatorN,
    sparse_weight_accumulator_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StPop,
        StFetch,
        StAccum,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic             dequeue_q, dequeue_d;
    logic             weight_read_q, weight_read_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [9:0]       addr_q;
    logic [9:0]       count_q;
    logic             err_q;
    logic             addr_valid;

    logic [ACC_W-1:0]    acc_q   [NODES];
    logic [ACC_W-1:0]    acc_sat [NODES];
    logic [ACC_W:0]      wide    [NODES];
    logic [WEIGHT_W-1:0] weight  [NODES];

    assign addr_valid = ({22'd0, addr_q} < INPUT_NODES);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StCheck;
            StCheck: state_d = bus.queueEmpty ? StDone : StPop;
            StPop:   state_d = StFetch;
            StFetch: state_d = StAccum;
            StAccum: state_d = StCheck;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Registered strobes are decoded from the state being entered
    always_comb begin
        dequeue_d     = (state_d == StPop);
        weight_read_d = (state_d == StFetch);
        done_d        = (state_d == StDone);
        busy_d        = (state_d != StIdle) && (state_d != StDone);
    end

    // State register and output strobes
    always_ff @(posedge clk or negedge resetAccumulatorN) begin
        if (!resetAccumulatorN) begin
            state_q       <= StIdle;
            dequeue_q     <= 1'b0;
            weight_read_q <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            dequeue_q     <= dequeue_d;
            weight_read_q <= weight_read_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
        end
    end

    // Saturating add: sum at ACC_W+1 bits, clamp when the top two bits disagree
    always_comb begin
        for (int k = 0; k < NODES; k++) begin
            weight[k]  = bus.weightData[k*WEIGHT_W +: WEIGHT_W];
            wide[k]    = {acc_q[k][ACC_W-1], acc_q[k]}
                       + {{(ACC_W + 1 - WEIGHT_W){weight[k][WEIGHT_W-1]}}, weight[k]};
            acc_sat[k] = (wide[k][ACC_W] == wide[k][ACC_W-1]) ? wide[k][ACC_W-1:0]
                       : {wide[k][ACC_W], {(ACC_W - 1){~wide[k][ACC_W]}}};
        end
    end

    // Datapath: address capture, accumulation, count and sticky index error
    always_ff @(posedge clk or negedge resetAccumulatorN) begin
        if (!resetAccumulatorN) begin
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            for (int k = 0; k < NODES; k++) acc_q[k] <= '0;
        end else begin
            if (state_q == StIdle && bus.start) begin
                count_q <= '0;
                err_q   <= 1'b0;
                for (int k = 0; k < NODES; k++) acc_q[k] <= '0;
            end
            if (state_q == StPop) addr_q <= bus.indexIn;
            if (state_q == StAccum) begin
                if (addr_valid) begin
                    count_q <= count_q + 10'd1;
                    for (int k = 0; k < NODES; k++) acc_q[k] <= acc_sat[k];
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NODES; g++) begin : g_sums
        assign bus.sums[g*ACC_W +: ACC_W] = acc_q[g];
    end

    assign bus.dequeue     = dequeue_q;
    assign bus.weightRead  = weight_read_q;
    assign bus.weightAddr  = addr_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;
    assign bus.activeCount = count_q;
    assign bus.indexError  = err_q;

endmodule

// File: tb/tb_sparse_weight_accumulator.sv
// Bench for sparse_weight_accumulator: a default-width DUT and an ACC_W=10 DUT run in
// lockstep off one index-queue / weight-memory model; results are compared against a
// plain-arithmetic reference computed from the queue contents and the weight table.
module tb_sparse_weight_accumulator;
    localparam int unsigned NODES       = 16;
    localparam int unsigned WEIGHT_W    = 8;
    localparam int unsigned ACC_W       = 18;
    localparam int unsigned ACC_W_SAT   = 10;
    localparam int unsigned INPUT_NODES = 784;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sparse_weight_accumulator_if #(.NODES(NODES), .WEIGHT_W(WEIGHT_W), .ACC_W(ACC_W)) bus ();
    sparse_weight_accumulator_if #(.NODES(NODES), .WEIGHT_W(WEIGHT_W), .ACC_W(ACC_W_SAT)) bus_s ();

    sparse_weight_accumulator #(
        .NODES(NODES), .WEIGHT_W(WEIGHT_W), .ACC_W(ACC_W), .INPUT_NODES(INPUT_NODES)
    ) dut (
        .clk(clk),
        .resetAccumulatorN(rst_n),
        .bus(bus)
    );

    sparse_weight_accumulator #(
        .NODES(NODES), .WEIGHT_W(WEIGHT_W), .ACC_W(ACC_W_SAT), .INPUT_NODES(INPUT_NODES)
    ) dut_sat (
        .clk(clk),
        .resetAccumulatorN(rst_n),
        .bus(bus_s)
    );

    assign bus_s.start      = bus.start;
    assign bus_s.queueEmpty = bus.queueEmpty;
    assign bus_s.indexIn    = bus.indexIn;
    assign bus_s.weightData = bus.weightData;

    int wmem [1024][NODES];
    int qdata[$];
    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sat_add(input longint a, input longint w, input int width);
        longint s  = a + w;
        longint hi = (longint'(1) << (width - 1)) - 1;
        longint lo = -hi - 1;
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

    function automatic longint node_sum(input int k, input bit narrow);
        if (narrow) return longint'($signed(bus_s.sums[k*ACC_W_SAT +: ACC_W_SAT]));
        return longint'($signed(bus.sums[k*ACC_W +: ACC_W]));
    endfunction

    task automatic drive_row(input int idx);
        for (int k = 0; k < NODES; k++) bus.weightData[k*WEIGHT_W +: WEIGHT_W] = 8'(wmem[idx][k]);
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < 1024; i++) for (int k = 0; k < NODES; k++) wmem[i][k] = v;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 1024; i++)
            for (int k = 0; k < NODES; k++) wmem[i][k] = int'($urandom_range(0, 255)) - 128;
    endtask

    // One accumulation pass over qdata; abort_fetch>0 asserts reset in that FETCH cycle.
    task automatic run_pass(input string name, input bit poke, input int abort_fetch);
        longint e18 [NODES];
        longint e10 [NODES];
        int     ecnt = 0;
        bit     eerr = 0;
        int     n = qdata.size();
        int     ptr = 0, pops = 0, fetches = 0, cyc = 1;
        bit     prev_deq = 0, prev_read = 0;

        for (int k = 0; k < NODES; k++) begin
            e18[k] = 0;
            e10[k] = 0;
        end
        foreach (qdata[i]) begin
            if (qdata[i] < int'(INPUT_NODES)) begin
                ecnt++;
                for (int k = 0; k < NODES; k++) begin
                    e18[k] = sat_add(e18[k], wmem[qdata[i]][k], ACC_W);
                    e10[k] = sat_add(e10[k], wmem[qdata[i]][k], ACC_W_SAT);
                end
            end else begin
                eerr = 1;
            end
        end

        bus.queueEmpty = (n == 0);
        bus.indexIn    = (n > 0) ? 10'(qdata[0]) : 10'd0;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;

        forever begin
            if (prev_deq) begin
                ptr++;
                bus.queueEmpty = (ptr >= n);
                if (ptr < n) bus.indexIn = 10'(qdata[ptr]);
            end
            if (prev_read) drive_row(int'(bus.weightAddr));
            else bus.weightData = {$urandom(), $urandom(), $urandom(), $urandom()};

            if (cyc == 1) check_eq({name, "_busy_early"}, bus.busy, 1);
            if (bus.dequeue) begin
                pops++;
                check_eq({name, "_deq_nonempty"}, longint'(ptr < n), 1);
            end
            if (bus.weightRead) begin
                fetches++;
                if (fetches <= n) check_eq({name, "_addr"}, bus.weightAddr, qdata[fetches-1]);
                else check_eq({name, "_extra_fetch"}, fetches, n);
                if (fetches == abort_fetch) begin
                    rst_n = 1'b0;
                    #1;
                    check_eq({name, "_rst_deq"}, bus.dequeue, 0);
                    check_eq({name, "_rst_read"}, bus.weightRead, 0);
                    check_eq({name, "_rst_busy"}, bus.busy, 0);
                    check_eq({name, "_rst_sums"}, longint'(bus.sums != '0), 0);
                    check_eq({name, "_rst_sums_sat"}, longint'(bus_s.sums != '0), 0);
                    return;
                end
            end
            if (bus.done || cyc >= 4 * n + 20) break;
            prev_deq  = bus.dequeue;
            prev_read = bus.weightRead;
            bus.start = poke && (cyc == 3);
            @(posedge clk); #1;
            cyc++;
        end

        check_eq({name, "_done_cycle"}, bus.done ? cyc : -1, 4 * n + 2);
        check_eq({name, "_busy_at_done"}, bus.busy, 0);
        check_eq({name, "_pops"}, pops, n);
        check_eq({name, "_count"}, bus.activeCount, ecnt);
        check_eq({name, "_err"}, bus.indexError, eerr);
        check_eq({name, "_sat_done"}, bus_s.done, 1);
        check_eq({name, "_sat_count"}, bus_s.activeCount, ecnt);
        for (int k = 0; k < NODES; k++) begin
            check_eq($sformatf("%s_sum%0d", name, k), node_sum(k, 0), e18[k]);
            check_eq($sformatf("%s_sat_sum%0d", name, k), node_sum(k, 1), e10[k]);
        end

        // a start coincident with DONE must be ignored
        bus.start = poke;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check_eq({name, "_done_pulse"}, bus.done, 0);
        check_eq({name, "_idle_busy"}, bus.busy, 0);
        check_eq({name, "_hold_sum0"}, node_sum(0, 0), e18[0]);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.queueEmpty = 1'b1;
        bus.indexIn    = '0;
        bus.weightData = '0;

        #3 rst_n = 1'b0;
        #1;
        check_eq("rst_deq", bus.dequeue, 0);
        check_eq("rst_read", bus.weightRead, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_err", bus.indexError, 0);
        check_eq("rst_addr", bus.weightAddr, 0);
        check_eq("rst_count", bus.activeCount, 0);
        check_eq("rst_sums", longint'(bus.sums != '0), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        qdata.delete();
        run_pass("empty", 1'b1, 0);

        for (int i = 0; i < 1024; i++) for (int k = 0; k < NODES; k++) wmem[i][k] = (i + k) % 128;
        qdata = {5, 100, 783};
        run_pass("three", 1'b1, 0);

        fill_const(-128);
        qdata.delete();
        for (int i = 0; i < int'(INPUT_NODES); i++) qdata.push_back(i);
        run_pass("neg784", 1'b0, 0);

        fill_const(127);
        qdata.delete();
        for (int i = 0; i < 10; i++) qdata.push_back(int'($urandom_range(0, 783)));
        run_pass("pos10", 1'b1, 0);

        fill_random();
        qdata = {7, 800, 300};
        run_pass("badidx", 1'b0, 0);
        qdata = {1};
        run_pass("errclear", 1'b0, 0);

        qdata = {10, 20, 30};
        run_pass("abort", 1'b0, 2);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        qdata = {40, 50};
        run_pass("after_rst", 1'b1, 0);

        for (int p = 0; p < 6; p++) begin
            int n = int'($urandom_range(0, 12));
            fill_random();
            qdata.delete();
            for (int i = 0; i < n; i++)
                qdata.push_back(($urandom_range(0, 19) == 0) ? int'($urandom_range(784, 1023))
                                                             : int'($urandom_range(0, 783)));
            run_pass($sformatf("rand%0d", p), 1'($urandom_range(0, 1)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
